// File: rtl/bin_avg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bin_avg_sequencer
//  Description : Control sequencer for the FFT bin-averaging datapath. Frames
//                FFT output beats into blocks of 2^navg beats and drives the
//                accumulator load/enable/dump strobes, the normalising shift,
//                the output-valid pulse and a completed-block counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_avg_sequencer #(
    parameter int N         = 16,
    parameter int SUM_WIDTH = 32
) (
    input  logic        clk,
    input  logic        arest_n,
    input  logic        i_enable,
    input  logic        i_fft_ready,
    input  logic [7:0]  i_n_avgs,
    output logic        o_acc_load,
    output logic        o_acc_en,
    output logic        o_dump,
    output logic [7:0]  o_avg_shift,
    output logic        o_valid,
    output logic        o_busy,
    output logic [15:0] o_block_cnt,
    output logic        o_cfg_clamped
);

    // Largest log2 average count that cannot overflow the accumulator.
    localparam int         c_MAX_AVG   = SUM_WIDTH - N;
    localparam int         c_CNT_W     = c_MAX_AVG + 1;
    localparam logic [7:0] c_MAX_AVG_8 = 8'(c_MAX_AVG);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t               r_state;
    logic [7:0]           r_navg;
    logic [c_CNT_W-1:0]   r_beat_cnt;

    logic                 w_req_over;
    logic [7:0]           w_req_navg;
    logic [c_CNT_W-1:0]   w_last_cnt;
    logic                 w_last_beat;

    // Clamp the requested average count and find the final beat of the block.
    always_comb begin
        w_req_over  = (i_n_avgs > c_MAX_AVG_8);
        w_req_navg  = w_req_over ? c_MAX_AVG_8 : i_n_avgs;
        w_last_cnt  = (c_CNT_W'(1) << r_navg) - c_CNT_W'(1);
        w_last_beat = (r_beat_cnt == w_last_cnt);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            r_state       <= S_IDLE;
            r_navg        <= 8'd0;
            r_beat_cnt    <= '0;
            o_acc_load    <= 1'b0;
            o_acc_en      <= 1'b0;
            o_dump        <= 1'b0;
            o_avg_shift   <= 8'd0;
            o_valid       <= 1'b0;
            o_busy        <= 1'b0;
            o_block_cnt   <= 16'd0;
            o_cfg_clamped <= 1'b0;
        end else begin
            // Valid trails dump by one cycle even if the block is then aborted.
            o_valid    <= o_dump;
            o_acc_load <= 1'b0;
            o_acc_en   <= 1'b0;
            o_dump     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // fft_ready is ignored here, including on the entry cycle.
                    if (i_enable) begin
                        r_state       <= S_ACCUM;
                        o_busy        <= 1'b1;
                        r_navg        <= w_req_navg;
                        o_avg_shift   <= w_req_navg;
                        r_beat_cnt    <= '0;
                        o_cfg_clamped <= o_cfg_clamped | w_req_over;
                    end
                end
                S_ACCUM: begin
                    if (!i_enable) begin
                        // Abort: partial block is dropped, counters untouched.
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end else if (i_fft_ready) begin
                        o_acc_en   <= 1'b1;
                        o_acc_load <= (r_beat_cnt == '0);
                        if (w_last_beat) begin
                            // Shift reported with the dump belongs to the block
                            // being dumped; the new request applies afterwards.
                            o_dump        <= 1'b1;
                            r_beat_cnt    <= '0;
                            o_block_cnt   <= o_block_cnt + 16'd1;
                            o_avg_shift   <= r_navg;
                            r_navg        <= w_req_navg;
                            o_cfg_clamped <= o_cfg_clamped | w_req_over;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
